// File: rtl/eth_frame_fifo_if.sv
// eth_frame_fifo_if: byte-wide AXI-Stream link carrying a frame-error flag in tuser
interface eth_frame_fifo_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;
  logic       tready;
  modport master(output tdata, tvalid, tlast, tuser, input tready);
  modport slave(input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_frame_fifo.sv
// eth_frame_fifo: store-and-forward frame buffer; defining ETH_FRAME_FIFO_STATS_EN adds frame counters
module eth_frame_fifo #(
  parameter int DEPTH = 4096,
  parameter int MAX_LEN = 1536,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  eth_frame_fifo_if.slave       s_axis,
  eth_frame_fifo_if.master      m_axis,
  output logic                  drop_pulse,
  output logic [1:0]            drop_cause,
  output logic [ADDR_W:0]       level
`ifdef ETH_FRAME_FIFO_STATS_EN
  ,
  output logic [31:0]           stat_frames_ok,
  output logic [31:0]           stat_frames_drop
`endif
);
  localparam int LEN_W = $clog2(MAX_LEN + 2);
  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;
  state_t state, state_nxt;
  logic [ADDR_W:0] wr_ptr, wr_nxt, commit_ptr, commit_nxt, rd_ptr;
  logic [LEN_W-1:0] len, len_nxt;
  logic [1:0] cause, cause_nxt;
  logic pulse_nxt, wr_en, accept, full, oversize, rdy;
  logic [8:0] mem [DEPTH];
  logic [8:0] head, skid;
  logic head_v, skid_v, pop, issue, keep_v;
  assign s_axis.tready = rdy;
  assign accept = s_axis.tvalid & s_axis.tready;
  assign full = (wr_ptr - rd_ptr) == (ADDR_W+1)'(DEPTH);
  assign oversize = (state == RECV) && (len >= LEN_W'(MAX_LEN));
  // Write FSM: speculative write, commit on good tlast, roll back to commit_ptr on any drop
  always_comb begin
    state_nxt = state;
    wr_nxt = wr_ptr;
    commit_nxt = commit_ptr;
    len_nxt = len;
    cause_nxt = cause;
    pulse_nxt = 1'b0;
    wr_en = 1'b0;
    if (accept) begin
      if (state == DROP) begin
        state_nxt = s_axis.tlast ? IDLE : DROP;
        wr_nxt = s_axis.tlast ? commit_ptr : wr_ptr;
        pulse_nxt = s_axis.tlast;
      end else if (full || oversize) begin
        cause_nxt = full ? 2'b10 : 2'b11;
        state_nxt = s_axis.tlast ? IDLE : DROP;
        wr_nxt = s_axis.tlast ? commit_ptr : wr_ptr;
        pulse_nxt = s_axis.tlast;
      end else begin
        wr_en = 1'b1;
        len_nxt = (state == IDLE) ? LEN_W'(1) : (len == LEN_W'(MAX_LEN + 1)) ? len : len + LEN_W'(1);
        state_nxt = s_axis.tlast ? IDLE : RECV;
        wr_nxt = (s_axis.tlast && s_axis.tuser) ? commit_ptr : wr_ptr + (ADDR_W+1)'(1);
        commit_nxt = (s_axis.tlast && !s_axis.tuser) ? wr_ptr + (ADDR_W+1)'(1) : commit_ptr;
        pulse_nxt = s_axis.tlast && s_axis.tuser;
        cause_nxt = (s_axis.tlast && s_axis.tuser) ? 2'b01 : cause;
      end
    end
  end
  // Write-side state, pointers and drop reporting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      commit_ptr <= '0;
      len <= '0;
      cause <= 2'b00;
      drop_pulse <= 1'b0;
      drop_cause <= 2'b00;
      rdy <= 1'b0;
    end else begin
      state <= state_nxt;
      wr_ptr <= wr_nxt;
      commit_ptr <= commit_nxt;
      len <= len_nxt;
      cause <= cause_nxt;
      drop_pulse <= pulse_nxt;
      drop_cause <= pulse_nxt ? cause_nxt : 2'b00;
      rdy <= 1'b1;
    end
  end
  // Frame storage, {tlast, tdata} per byte
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= {s_axis.tlast, s_axis.tdata};
  end
  assign pop = head_v & m_axis.tready;
  assign keep_v = pop ? skid_v : head_v;
  assign issue = (rd_ptr != commit_ptr) && (!skid_v || pop);
  // Read path: registered RAM read lands in head or skid so a stalled head never changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      head <= '0;
      skid <= '0;
      head_v <= 1'b0;
      skid_v <= 1'b0;
      level <= '0;
    end else begin
      rd_ptr <= issue ? rd_ptr + (ADDR_W+1)'(1) : rd_ptr;
      head <= (issue && !keep_v) ? mem[rd_ptr[ADDR_W-1:0]] : pop ? skid : head;
      skid <= (issue && keep_v) ? mem[rd_ptr[ADDR_W-1:0]] : skid;
      head_v <= keep_v | issue;
      skid_v <= (pop ? 1'b0 : skid_v) | (issue & keep_v);
      level <= commit_ptr - rd_ptr;
    end
  end
  assign m_axis.tdata = head[7:0];
  assign m_axis.tlast = head[8];
  assign m_axis.tvalid = head_v;
  assign m_axis.tuser = 1'b0;
`ifdef ETH_FRAME_FIFO_STATS_EN
  logic commit_ev;
  assign commit_ev = commit_nxt != commit_ptr;
  // Good and dropped frame counters, free-running modulo 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames_ok <= '0;
      stat_frames_drop <= '0;
    end else begin
      stat_frames_ok <= stat_frames_ok + {31'd0, commit_ev};
      stat_frames_drop <= stat_frames_drop + {31'd0, pulse_nxt};
    end
  end
`endif
endmodule

// File: tb/tb_eth_frame_fifo.sv
// tb_eth_frame_fifo: randomized and directed bench for eth_frame_fifo against a frame-level model
module tb_eth_frame_fifo;
  localparam int DEPTH = 4096;
  localparam int MAX_LEN = 1536;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic drop_pulse;
  logic [1:0] drop_cause;
  logic [12:0] level;
`ifdef ETH_FRAME_FIFO_STATS_EN
  logic [31:0] stat_ok, stat_drop;
`endif
  eth_frame_fifo_if s_if();
  eth_frame_fifo_if m_if();
  eth_frame_fifo dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_axis(s_if),
    .m_axis(m_if),
    .drop_pulse(drop_pulse),
    .drop_cause(drop_cause),
    .level(level)
`ifdef ETH_FRAME_FIFO_STATS_EN
    ,
    .stat_frames_ok(stat_ok),
    .stat_frames_drop(stat_drop)
`endif
  );
  always #10 clk = ~clk;
  int n_checks = 0, n_fail = 0, cyc = 0;
  // model: bytes of committed frames in delivery order, plus the frame being received
  logic [8:0] exp_q[$];
  logic [8:0] cur_q[$];
  int cur_len = 0, cur_cause = 0, com_bytes = 0, popped = 0, out_h1 = 0, out_h2 = 0;
  int ok_cnt = 0, drop_cnt = 0, rel_cnt = 0;
  logic exp_pulse = 1'b0;
  logic [1:0] exp_cause = 2'b00;
  logic prev_stall = 1'b0;
  logic [8:0] prev_word = '0;
  int n_pop = 0, n_last = 0, n_drop = 0, first_v_cyc = 0, tlast_cyc = 0;
  logic [1:0] last_cause = 2'b00;
  logic seen_v = 1'b0, rnd_rdy = 1'b0, fix_rdy = 1'b1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1 m_if.tready = rnd_rdy ? 1'($urandom_range(1)) : fix_rdy;
    end
  end
  // compare process: every negedge, check outputs then advance the model by what the next edge accepts
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_tvalid", m_if.tvalid, 0);
      chk("rst_tlast", m_if.tlast, 0);
      chk("rst_tdata", m_if.tdata, 0);
      chk("rst_drop_pulse", drop_pulse, 0);
      chk("rst_drop_cause", drop_cause, 0);
      chk("rst_level", level, 0);
      chk("rst_s_tready", s_if.tready, 0);
      exp_q.delete();
      cur_q.delete();
      cur_len = 0; cur_cause = 0; com_bytes = 0; popped = 0; out_h1 = 0; out_h2 = 0;
      ok_cnt = 0; drop_cnt = 0; rel_cnt = 0; exp_pulse = 1'b0; prev_stall = 1'b0;
    end else begin
      rel_cnt++;
      chk("s_tready", s_if.tready, rel_cnt >= 2);
      chk("drop_pulse", drop_pulse, exp_pulse);
      if (exp_pulse) chk("drop_cause", drop_cause, exp_cause);
      if (drop_pulse) begin
        n_drop++;
        last_cause = drop_cause;
      end
      n_checks++;
      if (int'(level) > out_h2 || int'(level) + 2 < out_h2) begin
        n_fail++;
        $display("FAIL level: got %0d, expected %0d..%0d", level, out_h2 - 2, out_h2);
      end
`ifdef ETH_FRAME_FIFO_STATS_EN
      chk("stat_ok", stat_ok, ok_cnt);
      chk("stat_drop", stat_drop, drop_cnt);
`endif
      if (prev_stall) begin
        chk("stall_tvalid", m_if.tvalid, 1);
        chk("stall_word", {m_if.tlast, m_if.tdata}, prev_word);
      end
      if (m_if.tvalid) begin
        if (!seen_v) begin
          seen_v = 1'b1;
          first_v_cyc = cyc;
        end
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_spurious: got tvalid=1 data %0d, expected no byte", m_if.tdata);
        end else chk("out_word", {m_if.tlast, m_if.tdata}, exp_q[0]);
      end
      prev_stall = m_if.tvalid & !m_if.tready;
      prev_word = {m_if.tlast, m_if.tdata};
      exp_pulse = 1'b0;
      if (s_if.tvalid && s_if.tready) begin
        if (cur_cause == 0) begin
          if (com_bytes - popped + cur_len >= DEPTH + 2) cur_cause = 2;
          else if (cur_len >= MAX_LEN) cur_cause = 3;
          else cur_q.push_back({s_if.tlast, s_if.tdata});
        end
        cur_len++;
        if (s_if.tlast) begin
          if (cur_cause != 0 || s_if.tuser) begin
            exp_pulse = 1'b1;
            exp_cause = (cur_cause != 0) ? 2'(cur_cause) : 2'b01;
            drop_cnt++;
          end else begin
            foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
            com_bytes += cur_len;
            ok_cnt++;
          end
          cur_q.delete();
          cur_len = 0;
          cur_cause = 0;
        end
      end
      if (m_if.tvalid && m_if.tready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        popped++;
        n_pop++;
        if (m_if.tlast) n_last++;
      end
      out_h2 = out_h1;
      out_h1 = com_bytes - popped;
    end
  end
  // mode 0: byte i, mode 1: 0xAA, mode 2: random; tuser is noise except on tlast
  task automatic send_frame(input int n, input int mode, input logic err, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        s_if.tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_if.tvalid = 1'b1;
      s_if.tdata = (mode == 0) ? 8'(i) : (mode == 1) ? 8'hAA : 8'($urandom);
      s_if.tlast = (i == n - 1);
      s_if.tuser = (i == n - 1) ? err : 1'($urandom_range(1));
      if (i == n - 1) tlast_cyc = cyc;
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast = 1'b0;
    s_if.tuser = 1'b0;
  endtask
  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_if.tvalid) && t < 20000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk({name, "_drain_in_time"}, t < 20000, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic wait_ready();
    int t;
    t = 0;
    while (!s_if.tready && t < 10) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("ready_after_reset", s_if.tready, 1);
  endtask
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
  initial begin
    int t1_last, good_bytes, n, t;
    logic err;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready();
    // back-to-back good frames
    seen_v = 1'b0; n_pop = 0; n_last = 0; n_drop = 0;
    send_frame(64, 0, 1'b0, 0);
    t1_last = tlast_cyc;
    send_frame(1, 1, 1'b0, 0);
    drain("t1");
    chk("t1_latency", first_v_cyc, t1_last + 2);
    chk("t1_bytes", n_pop, 65);
    chk("t1_tlasts", n_last, 2);
    chk("t1_drops", n_drop, 0);
    // errored frame then good frame
    n_pop = 0; n_drop = 0;
    send_frame(100, 2, 1'b1, 0);
    send_frame(10, 0, 1'b0, 0);
    drain("t2");
    chk("t2_bytes", n_pop, 10);
    chk("t2_drops", n_drop, 1);
    chk("t2_cause", last_cause, 2'b01);
    chk("t2_level", level, 0);
    // overflow with downstream stalled
    fix_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_pop = 0; n_drop = 0;
    repeat (3) send_frame(1536, 2, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t3_drops", n_drop, 1);
    chk("t3_cause", last_cause, 2'b10);
    fix_rdy = 1'b1;
    drain("t3");
    chk("t3_bytes", n_pop, 3072);
    // oversize then minimum-size frame
    n_pop = 0; n_drop = 0;
    send_frame(1537, 2, 1'b0, 0);
    send_frame(46, 0, 1'b0, 0);
    drain("t4");
    chk("t4_drops", n_drop, 1);
    chk("t4_cause", last_cause, 2'b11);
    chk("t4_bytes", n_pop, 46);
    // random frames under random backpressure, paced so the buffer cannot overflow
    rnd_rdy = 1'b1;
    n_pop = 0; good_bytes = 0;
    for (int f = 0; f < 200; f++) begin
      n = ($urandom_range(15) == 0) ? int'($urandom_range(1536, 65)) : int'($urandom_range(64, 1));
      err = ($urandom_range(9) == 0);
      t = 0;
      while (com_bytes - popped + n > DEPTH && t < 50000) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (t >= 50000) chk("t5_space_wait", t, 0);
      send_frame(n, 2, err, 20);
      if (!err) good_bytes += n;
    end
    drain("t5");
    chk("t5_bytes", n_pop, good_bytes);
    rnd_rdy = 1'b0;
    // reset in the middle of a frame
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      s_if.tdata = 8'(i);
      s_if.tlast = 1'b0;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("t6_async_s_tready", s_if.tready, 0);
    chk("t6_async_tvalid", m_if.tvalid, 0);
    chk("t6_async_level", level, 0);
    s_if.tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready();
`ifdef ETH_FRAME_FIFO_STATS_EN
    chk("t6_stat_ok_zero", stat_ok, 0);
    chk("t6_stat_drop_zero", stat_drop, 0);
`endif
    n_pop = 0;
    send_frame(500, 0, 1'b0, 0);
    drain("t6");
    chk("t6_bytes", n_pop, 500);
`ifdef ETH_FRAME_FIFO_STATS_EN
    chk("t6_stat_ok_one", stat_ok, 1);
`endif
    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
